bcd_to_level: RTL and testbench

- Inverse of the oscilloscope's binary-to-BCD voltage readout path.
- Converts a user-entered 5-digit packed BCD voltage (D1.D2D3D4D5 V) into the equivalent binary ADC code, code = round(V × SCALE).
- The trigger-level and cursor logic uses the result to compare directly against raw samples.
- Sequential: digit-serial multiply-accumulate, one constant multiply, then a 32-step restoring division by 10^4.

---
 rtl/bcd_to_level.sv | 136 +++++++++++++
 tb/tb_bcd_to_level.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_level.sv
// bcd_to_level: converts a 5-digit packed BCD voltage (D1.D2D3D4D5 V) into
// the matching binary ADC code, code = round(V * SCALE).
// The digits are folded into a binary integer one per clock, scaled by SCALE
// with a half-LSB offset, then divided by 10^4 with a bit-serial restoring
// divider. The result is presented with a fixed, data-independent latency.

module bcd_to_level #(
  parameter int SCALE = 820,
  parameter int DIV   = 10000
) (
  input  logic        CLK,
  input  logic        RSTB,
  input  logic        START,
  input  logic [19:0] BCD_IN,
  output logic [31:0] DATA_OUT,
  output logic        busy,
  output logic        ready,
  output logic        err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ACCUM    = 3'd1;
  localparam logic [2:0] SCALE_ST = 3'd2;
  localparam logic [2:0] DIVIDE   = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [31:0] SCALE_W = 32'(SCALE);
  localparam logic [31:0] DIV_W   = 32'(DIV);
  localparam logic [32:0] DIV_X   = 33'(DIV);
  localparam logic [31:0] HALF_W  = 32'(DIV / 2);

  logic [2:0]  state;
  logic [19:0] bcd_reg;
  logic [16:0] acc;
  logic [31:0] dvd;
  logic [31:0] rem;
  logic [5:0]  cnt;

  logic        bad_digit;
  logic [16:0] acc_next;
  logic [31:0] product;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;

  // Flag a latched request whose digits are not all decimal
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bcd_reg[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Datapath: digit accumulate, scale with rounding offset, one divider step
  always_comb begin
    acc_next  = (acc * 17'd10) + {13'd0, bcd_reg[19:16]};
    product   = ({15'd0, acc} * SCALE_W) + HALF_W;
    rem_shift = {rem, dvd[31]};
    rem_ge    = (rem_shift >= DIV_X);
    rem_sub   = rem_shift[31:0] - DIV_W;
  end

  // Conversion sequencer: accept, accumulate digits, scale, divide, present
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state    <= IDLE;
      bcd_reg  <= '0;
      acc      <= '0;
      dvd      <= '0;
      rem      <= '0;
      cnt      <= '0;
      DATA_OUT <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (START) begin
            bcd_reg <= BCD_IN;
            acc     <= '0;
            dvd     <= '0;
            rem     <= '0;
            cnt     <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if ((cnt == 6'd0) && bad_digit) begin
            DATA_OUT <= '0;
            err      <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            acc     <= acc_next;
            bcd_reg <= {bcd_reg[15:0], 4'h0};
            if (cnt == 6'd4) begin
              cnt   <= '0;
              state <= SCALE_ST;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        SCALE_ST: begin
          dvd   <= product;
          rem   <= '0;
          cnt   <= '0;
          state <= DIVIDE;
        end
        DIVIDE: begin
          if (cnt == 6'd32) begin
            DATA_OUT <= dvd;
            ready    <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            rem <= rem_ge ? rem_sub : rem_shift[31:0];
            dvd <= {dvd[30:0], rem_ge};
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_level.sv
// tb_bcd_to_level: scoreboard bench for bcd_to_level. Each request pushes its
// expected code, error flag and latency; the entry is popped and compared
// when ready rises.

module tb_bcd_to_level;

  logic        CLK = 1'b0;
  logic        RSTB = 1'b0;
  logic        START = 1'b0;
  logic [19:0] BCD_IN = '0;
  logic [31:0] DATA_OUT;
  logic        busy;
  logic        ready;
  logic        err;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          compare_count = 0;
  int          mismatch_count = 0;
  logic [31:0] last_result = '0;

  bcd_to_level dut (
    .CLK      (CLK),
    .RSTB     (RSTB),
    .START    (START),
    .BCD_IN   (BCD_IN),
    .DATA_OUT (DATA_OUT),
    .busy     (busy),
    .ready    (ready),
    .err      (err)
  );

  // Free-running 100 MHz clock
  always #5 CLK = ~CLK;

  // Hard stop if something hangs
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %0d required %0d", tag, observed, expected);
    end
  endtask

  task automatic pushExpect(input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    e.data = exp_data;
    e.err  = exp_err;
    e.lat  = exp_err ? 1 : 39;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for ready after an accept edge, then score the result
  task automatic waitAndScore(input bit pulse_during);
    exp_t got;
    int   edges;
    int   busy_cycles;
    edges       = 0;
    busy_cycles = 0;
    while (ready !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) busy_cycles++;
      if (edges == 20) checkOutput("data_held_mid", DATA_OUT, last_result);
      if (pulse_during && (edges == 9 || edges == 19)) begin
        START  = 1'b1;
        BCD_IN = 20'h50000;
      end
      @(posedge CLK);
      #1;
      edges++;
      START = 1'b0;
    end
    got = sb_q.pop_front();
    checkOutput("latency", 32'(edges), 32'(got.lat));
    checkOutput("busy_cycles", 32'(busy_cycles), 32'(got.lat));
    checkOutput("data_out", DATA_OUT, got.data);
    checkOutput("err", 32'(err), 32'(got.err));
    checkOutput("busy_done", 32'(busy), 32'd0);
    last_result = got.data;
  endtask

  task automatic applyStimulus(input logic [19:0] bcd, input logic [31:0] exp_data,
                               input logic exp_err, input bit pulse_during);
    pushExpect(exp_data, exp_err);
    @(negedge CLK);
    START  = 1'b1;
    BCD_IN = bcd;
    @(posedge CLK);
    #1;
    START = 1'b0;
    checkOutput("ready_after_accept", 32'(ready), 32'd0);
    checkOutput("err_after_accept", 32'(err), 32'd0);
    if (exp_err) begin
      checkOutput("busy_after_accept", 32'(busy), 32'd1);
      @(posedge CLK);
      #1;
      begin
        exp_t got;
        got = sb_q.pop_front();
        checkOutput("bad_ready", 32'(ready), 32'd1);
        checkOutput("bad_err", 32'(err), 32'(got.err));
        checkOutput("bad_busy", 32'(busy), 32'd0);
        checkOutput("bad_data", DATA_OUT, got.data);
        last_result = got.data;
      end
    end else begin
      waitAndScore(pulse_during);
    end
  endtask

  initial begin
    $display("[TB] bcd_to_level bench starting");
    RSTB = 1'b0;
    #12;
    checkOutput("reset_data", DATA_OUT, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    @(negedge CLK);
    RSTB = 1'b1;

    applyStimulus(20'h10000, 32'd820,  1'b0, 1'b0);
    applyStimulus(20'h99999, 32'd8200, 1'b0, 1'b0);
    applyStimulus(20'h25000, 32'd2050, 1'b0, 1'b0);
    applyStimulus(20'h00000, 32'd0,    1'b0, 1'b0);
    applyStimulus(20'h00006, 32'd0,    1'b0, 1'b0);
    applyStimulus(20'h00007, 32'd1,    1'b0, 1'b0);
    applyStimulus(20'h00061, 32'd5,    1'b0, 1'b0);
    applyStimulus(20'h1A000, 32'd0,    1'b1, 1'b0);
    applyStimulus(20'h10000, 32'd820,  1'b0, 1'b0);
    applyStimulus(20'h10000, 32'd820,  1'b0, 1'b1);
    applyStimulus(20'h50000, 32'd4100, 1'b0, 1'b0);

    // START held high: two conversions, second accepted from DONE
    pushExpect(32'd5, 1'b0);
    pushExpect(32'd5, 1'b0);
    @(negedge CLK);
    START  = 1'b1;
    BCD_IN = 20'h00061;
    @(posedge CLK);
    #1;
    begin
      int edges;
      edges = 0;
      while (ready !== 1'b1 && edges < 100) begin
        @(posedge CLK);
        #1;
        edges++;
      end
      begin
        exp_t got;
        got = sb_q.pop_front();
        checkOutput("b2b_latency1", 32'(edges), 32'(got.lat));
        checkOutput("b2b_data1", DATA_OUT, got.data);
        last_result = got.data;
      end
      @(posedge CLK);
      #1;
      START = 1'b0;
      checkOutput("b2b_reaccept_ready", 32'(ready), 32'd0);
      checkOutput("b2b_reaccept_busy", 32'(busy), 32'd1);
    end
    waitAndScore(1'b0);

    // Reset in the middle of a conversion aborts it immediately
    @(negedge CLK);
    START  = 1'b1;
    BCD_IN = 20'h99999;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    checkOutput("pre_abort_busy", 32'(busy), 32'd1);
    RSTB = 1'b0;
    #1;
    checkOutput("abort_data", DATA_OUT, 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(ready), 32'd0);
    checkOutput("abort_err", 32'(err), 32'd0);
    @(negedge CLK);
    RSTB = 1'b1;
    last_result = 32'd0;
    repeat (2) @(negedge CLK);
    checkOutput("idle_after_abort_ready", 32'(ready), 32'd0);
    applyStimulus(20'h30000, 32'd2460, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
